// File: rtl/esm_pkg.sv
// Shared definitions for the ESM instruction dispatcher: FSM state encoding
// and default parameter values.
package esm_pkg;

    localparam int DEF_INSTR_W = 32;
    localparam int DEF_BS      = 16;
    localparam int DEF_AW      = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRIME  = 3'd1,
        ST_FILL   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_FINISH = 3'd4
    } disp_state_e;

endpackage

// File: rtl/dispatch_drain_timer.sv
// Down-counter that times the idle gap after each dispatched batch.
// load arms it for CYCLES enabled cycles; expired flags the last enabled one.
module dispatch_drain_timer #(
    parameter int CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic enable,
    output logic expired
);

    // A zero-length gap still costs one cycle, so the counter never has zero width.
    localparam int TW = (CYCLES < 1) ? 1 : $clog2(CYCLES + 1);

    logic [TW-1:0] count_q, count_d;

    // Next count: reload on entry to the gap, otherwise count down while enabled.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = TW'(CYCLES);
        end else if (enable && (count_q != '0)) begin
            count_d = count_q - TW'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q <= TW'(1));

endmodule

// File: rtl/instr_dispatch.sv
// Fetches a program from instruction memory and streams it to the ESM in
// batches of up to bs instructions, each followed by an idle drain gap.
// One fetch is kept in flight; a one-entry skid register catches the word
// that lands while hold is asserted.
module instr_dispatch
    import esm_pkg::*;
#(
    parameter int Instruction_word_size = DEF_INSTR_W,
    parameter int bs                    = DEF_BS,
    parameter int AW                    = DEF_AW,
    parameter int DRAIN_CYCLES          = bs
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [AW:0]                      prog_len,
    input  logic                             hold,
    output logic                             mem_en,
    output logic [AW-1:0]                    mem_addr,
    input  logic [Instruction_word_size-1:0] mem_rdata,
    output logic [Instruction_word_size-1:0] Instr_in,
    output logic                             valid_flag,
    output logic                             busy,
    output logic                             done
);

    localparam int             BW   = $clog2(bs + 1);
    localparam logic [BW:0]    BS_V = (BW + 1)'(bs);

    disp_state_e                      state_q, state_d;
    logic [AW:0]                      len_q, len_d;
    logic [AW:0]                      pc_q, pc_d;
    logic [AW:0]                      total_q, total_d;
    logic [BW-1:0]                    batch_q, batch_d;
    logic                             rvld_q, rvld_d;
    logic                             skid_vld_q, skid_vld_d;
    logic [Instruction_word_size-1:0] skid_q, skid_d;
    logic [Instruction_word_size-1:0] instr_in_q, instr_in_d;
    logic                             valid_flag_q, valid_flag_d;
    logic                             busy_q, busy_d;
    logic                             done_q, done_d;

    logic        fetch;
    logic        timer_load, timer_en, timer_exp;
    logic [AW+1:0] total_nxt;
    logic [BW:0]   batch_nxt;
    logic        more_total, more_batch;

    // Counts after the instruction issued this cycle; extra top bit keeps
    // prog_len = 2^AW comparisons exact.
    assign total_nxt  = {1'b0, total_q} + (AW + 2)'(1);
    assign batch_nxt  = {1'b0, batch_q} + (BW + 1)'(1);
    assign more_total = total_nxt < {1'b0, len_q};
    assign more_batch = batch_nxt < BS_V;

    dispatch_drain_timer #(
        .CYCLES(DRAIN_CYCLES)
    ) u_drain_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timer_load),
        .enable (timer_en),
        .expired(timer_exp)
    );

    // Next-state and datapath decisions; the fetch for instruction i+1 is
    // issued in the same cycle instruction i is handed to the ESM.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        pc_d         = pc_q;
        total_d      = total_q;
        batch_d      = batch_q;
        skid_vld_d   = skid_vld_q;
        skid_d       = skid_q;
        instr_in_d   = instr_in_q;
        valid_flag_d = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        fetch        = 1'b0;
        timer_load   = 1'b0;
        timer_en     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d      = prog_len;
                    pc_d       = '0;
                    total_d    = '0;
                    batch_d    = '0;
                    skid_vld_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = (prog_len == '0) ? ST_FINISH : ST_PRIME;
                end
            end
            ST_PRIME: begin
                if (!hold) begin
                    fetch   = 1'b1;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (hold) begin
                    // Word from last cycle's fetch must not be dropped.
                    if (rvld_q) begin
                        skid_d     = mem_rdata;
                        skid_vld_d = 1'b1;
                    end
                end else if (skid_vld_q || rvld_q) begin
                    instr_in_d   = skid_vld_q ? skid_q : mem_rdata;
                    valid_flag_d = 1'b1;
                    skid_vld_d   = 1'b0;
                    total_d      = total_nxt[AW:0];
                    batch_d      = batch_nxt[BW-1:0];
                    if (more_total && more_batch) begin
                        fetch = 1'b1;
                    end else begin
                        timer_load = 1'b1;
                        state_d    = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!hold) begin
                    timer_en = 1'b1;
                    if (timer_exp) begin
                        if (total_q < len_q) begin
                            batch_d = '0;
                            state_d = ST_PRIME;
                        end else begin
                            state_d = ST_FINISH;
                        end
                    end
                end
            end
            ST_FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fetch) begin
            pc_d = pc_q + (AW + 1)'(1);
        end
        rvld_d = fetch;
    end

    // State, counters, skid and output registers; reset aborts any run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            pc_q         <= '0;
            total_q      <= '0;
            batch_q      <= '0;
            rvld_q       <= 1'b0;
            skid_vld_q   <= 1'b0;
            skid_q       <= '0;
            instr_in_q   <= '0;
            valid_flag_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            pc_q         <= pc_d;
            total_q      <= total_d;
            batch_q      <= batch_d;
            rvld_q       <= rvld_d;
            skid_vld_q   <= skid_vld_d;
            skid_q       <= skid_d;
            instr_in_q   <= instr_in_d;
            valid_flag_q <= valid_flag_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign mem_en     = fetch;
    assign mem_addr   = pc_q[AW-1:0];
    assign Instr_in   = instr_in_q;
    assign valid_flag = valid_flag_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_instr_dispatch.sv
// Scoreboard bench for instr_dispatch: stimulus pushes expected instructions
// (with the cycle they must appear), fetch addresses and done cycles; monitors
// pop and compare whenever the DUTs present valid_flag, mem_en or done.
`timescale 1ns/1ps
module tb_instr_dispatch;

    localparam int BS     = 16;
    localparam int DC     = 16;
    // Batch start to next batch start: bs issue cycles, drain gap, one prime cycle.
    localparam int PERIOD = BS + DC + 1;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n, start, hold;
    logic [8:0]  prog_len;
    logic        mem_en, valid_flag, busy, done;
    logic [7:0]  mem_addr;
    logic [31:0] mem_rdata, instr_in;

    logic        start4, hold4;
    logic [4:0]  prog_len4;
    logic        mem_en4, valid_flag4, busy4, done4;
    logic [3:0]  mem_addr4;
    logic [31:0] mem_rdata4, instr_in4;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int men_cnt = 0;

    exp_t exp_q[$];
    int   addr_q[$];
    int   done_q[$];
    exp_t exp4_q[$];
    int   addr4_q[$];
    int   done4_q[$];

    instr_dispatch dut (
        .clk(clk), .rst_n(rst_n), .start(start), .prog_len(prog_len), .hold(hold),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .Instr_in(instr_in), .valid_flag(valid_flag), .busy(busy), .done(done)
    );

    instr_dispatch #(.AW(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .prog_len(prog_len4), .hold(hold4),
        .mem_en(mem_en4), .mem_addr(mem_addr4), .mem_rdata(mem_rdata4),
        .Instr_in(instr_in4), .valid_flag(valid_flag4), .busy(busy4), .done(done4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memf(input int a);
        return {8'hA5, 8'(a), 16'(a * 37 + 11)};
    endfunction

    // Synchronous instruction memories: data one cycle after mem_en.
    always @(posedge clk) if (mem_en)  mem_rdata  <= memf(int'(mem_addr));
    always @(posedge clk) if (mem_en4) mem_rdata4 <= memf(int'(mem_addr4));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    // Expected timing: instruction i of a run started in cycle n0 shows at
    // n0+3 + batch*PERIOD + offset; instructions from sh_from on are delayed
    // by sh held cycles; done follows the last instruction by DC+1 (+ held
    // drain cycles), or n0+2 for an empty program.
    task automatic push_seq(input int n0, input int len, input int npush, input int naddr,
                            input int sh_from, input int sh, input int dextra,
                            input bit with_done, input bit d4);
        exp_t e;
        int   c;
        for (int i = 0; i < npush; i++) begin
            e.data = memf(i);
            e.cyc  = n0 + 3 + (i / BS) * PERIOD + (i % BS) + ((i >= sh_from) ? sh : 0);
            if (d4) exp4_q.push_back(e); else exp_q.push_back(e);
        end
        for (int i = 0; i < naddr; i++) begin
            if (d4) addr4_q.push_back(i); else addr_q.push_back(i);
        end
        if (with_done) begin
            if (len == 0) c = n0 + 2;
            else c = n0 + 3 + ((len - 1) / BS) * PERIOD + ((len - 1) % BS)
                     + ((len - 1 >= sh_from) ? sh : 0) + DC + 1 + dextra;
            if (d4) done4_q.push_back(c); else done_q.push_back(c);
        end
    endtask

    task automatic wait_empty(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() + addr_q.size() + done_q.size() +
                exp4_q.size() + addr4_q.size() + done4_q.size()) != 0 && k < budget) begin
            step();
            k++;
        end
        if ((exp_q.size() + addr_q.size() + done_q.size() +
             exp4_q.size() + addr4_q.size() + done4_q.size()) != 0) begin
            flag("timeout waiting for expected outputs");
            exp_q.delete(); addr_q.delete(); done_q.delete();
            exp4_q.delete(); addr4_q.delete(); done4_q.delete();
        end
        repeat (4) step();
    endtask

    // Monitor for the AW=8 instance.
    always @(negedge clk) begin
        exp_t e;
        if (valid_flag) begin
            if (exp_q.size() == 0) flag("unexpected valid_flag");
            else begin
                e = exp_q.pop_front();
                chk("instr_data", instr_in, e.data);
                chk("instr_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (mem_en) begin
            men_cnt++;
            if (hold) flag("mem_en during hold");
            if (addr_q.size() == 0) flag("unexpected mem_en");
            else chk("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
        end
        if (done) begin
            chk("busy_at_done", 32'(busy), 32'd0);
            if (done_q.size() == 0) flag("unexpected done");
            else chk("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
        end
    end

    // Monitor for the AW=4 instance.
    always @(negedge clk) begin
        exp_t e;
        if (valid_flag4) begin
            if (exp4_q.size() == 0) flag("aw4 unexpected valid_flag");
            else begin
                e = exp4_q.pop_front();
                chk("aw4_instr_data", instr_in4, e.data);
                chk("aw4_instr_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (mem_en4) begin
            if (addr4_q.size() == 0) flag("aw4 unexpected mem_en");
            else chk("aw4_mem_addr", 32'(mem_addr4), 32'(addr4_q.pop_front()));
        end
        if (done4) begin
            if (done4_q.size() == 0) flag("aw4 unexpected done");
            else chk("aw4_done_cycle", 32'(cyc), 32'(done4_q.pop_front()));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1, c0;
        rst_n = 1'b0; start = 1'b0; hold = 1'b0; prog_len = '0;
        start4 = 1'b0; hold4 = 1'b0; prog_len4 = '0;
        repeat (3) step();
        chk("rst_valid_flag", 32'(valid_flag), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_instr_in", instr_in, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        repeat (2) step();

        // Short program; prog_len changed after start must be ignored.
        start = 1'b1; prog_len = 9'd5; n0 = cyc;
        push_seq(n0, 5, 5, 5, 999, 0, 0, 1'b1, 1'b0);
        step();
        start = 1'b0; prog_len = 9'd2;
        chk("busy_after_start", 32'(busy), 32'd1);
        wait_empty(200);

        // Three batches 16/16/8; a start pulse mid-run must be ignored.
        start = 1'b1; prog_len = 9'd40; n0 = cyc;
        push_seq(n0, 40, 40, 40, 999, 0, 0, 1'b1, 1'b0);
        step();
        start = 1'b0;
        run_to(n0 + 25);
        start = 1'b1; prog_len = 9'd3;
        step();
        start = 1'b0;
        wait_empty(300);

        // Hold for 3 cycles exactly when instruction 7 would be issued.
        start = 1'b1; prog_len = 9'd10; n0 = cyc;
        push_seq(n0, 10, 10, 10, 7, 3, 0, 1'b1, 1'b0);
        step();
        start = 1'b0;
        run_to(n0 + 9);  hold = 1'b1;
        run_to(n0 + 12); hold = 1'b0;
        wait_empty(200);

        // Hold on the last issue (delays FILL->DRAIN) and inside DRAIN (freezes the gap).
        start = 1'b1; prog_len = 9'd3; n0 = cyc;
        push_seq(n0, 3, 3, 3, 2, 2, 2, 1'b1, 1'b0);
        step();
        start = 1'b0;
        run_to(n0 + 4);  hold = 1'b1;
        run_to(n0 + 6);  hold = 1'b0;
        run_to(n0 + 10); hold = 1'b1;
        run_to(n0 + 12); hold = 1'b0;
        wait_empty(200);

        // Empty program: done two cycles after start, no fetch, no valid.
        c0 = men_cnt;
        start = 1'b1; prog_len = 9'd0; n0 = cyc;
        push_seq(n0, 0, 0, 0, 999, 0, 0, 1'b1, 1'b0);
        step();
        start = 1'b0;
        wait_empty(50);
        chk("len0_mem_en_count", 32'(men_cnt), 32'(c0));

        // Reset while instruction 10 of 40 is on the bus, then a fresh run.
        start = 1'b1; prog_len = 9'd40; n0 = cyc;
        push_seq(n0, 40, 11, 13, 999, 0, 0, 1'b0, 1'b0);
        step();
        start = 1'b0;
        run_to(n0 + 13);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_valid_flag", 32'(valid_flag), 32'd0);
        chk("abort_mem_en", 32'(mem_en), 32'd0);
        chk("abort_mem_addr", 32'(mem_addr), 32'd0);
        chk("abort_instr_in", instr_in, 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        start = 1'b1; prog_len = 9'd5; n1 = cyc;
        push_seq(n1, 5, 5, 5, 999, 0, 0, 1'b1, 1'b0);
        step();
        start = 1'b0;
        wait_empty(200);

        // AW=4 instance: full address space, each address exactly once.
        start4 = 1'b1; prog_len4 = 5'd16; n0 = cyc;
        push_seq(n0, 16, 16, 16, 999, 0, 0, 1'b1, 1'b1);
        step();
        start4 = 1'b0;
        wait_empty(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_dispatch.md
INSTR_DISPATCH -- requirements
Module: instr_dispatch

Interface
REQ-001 Parameters SHALL be: Instruction_word_size, default 32, instruction width; bs, default 16, ESM buffer depth in instructions; AW, default 8, instruction-memory address width; DRAIN_CYCLES, default bs, idle cycles between batches.
REQ-002 Ports SHALL be (name  direction  width  meaning):
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse that begins a program run
prog_len  in  AW+1  number of instructions to dispatch, 0..2^AW
hold  in  1  stall request; freezes dispatch while high
mem_en  out  1  instruction-memory read enable
mem_addr  out  AW  instruction-memory read address
mem_rdata  in  Instruction_word_size  read data, valid one cycle after mem_en
Instr_in  out  Instruction_word_size  instruction driven to the ESM
valid_flag  out  1  Instr_in valid qualifier to the ESM
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the last batch drains
REQ-003 The block SHALL have one clock, clk; reset SHALL be synchronous and active-low, rst_n.

Function
REQ-004 The FSM SHALL have states IDLE, PRIME, FILL, DRAIN and FINISH.
REQ-005 In IDLE with start=1: prog_len=0 -> FINISH; otherwise -> PRIME. start SHALL be ignored in every other state.
REQ-006 PRIME SHALL assert mem_en with mem_addr=pc (pc=0 at run start), then move to FILL.
REQ-007 In FILL each non-held cycle SHALL register mem_rdata into Instr_in with valid_flag=1, increment the batch and total counters, and issue the next fetch while total+1 < prog_len and batch+1 < bs.
REQ-008 Timing: start sampled in cycle N -> mem_en in N+1 -> first valid_flag=1 in N+3; after that, one instruction per cycle with no bubbles unless hold is high.
REQ-009 FILL -> DRAIN when bs instructions of the batch are issued or the total reaches prog_len; valid_flag SHALL be 0 throughout DRAIN, so the ESM sees an empty/full condition and issues.
REQ-010 DRAIN SHALL last exactly DRAIN_CYCLES non-held cycles, then go to PRIME (batch cleared) if total < prog_len, else to FINISH.
REQ-011 FINISH SHALL pulse done for exactly one cycle, deassert busy, and return to IDLE.
REQ-012 While hold=1: valid_flag=0, no counter advances, mem_en=0, and the DRAIN timer is frozen. A fetch already in flight SHALL be captured in a one-entry skid register and issued first after hold drops. No instruction SHALL be lost or duplicated.
REQ-013 hold arriving in the same cycle as a FILL->DRAIN transition SHALL delay the transition, with no partial issue.
REQ-014 The total counter SHALL be AW+1 bits wide. prog_len=2^AW SHALL dispatch every address 0..2^AW-1 with no mem_addr wrap-around. mem_addr SHALL equal the low AW bits of pc.
REQ-015 The final batch MAY be shorter than bs and SHALL still be followed by a full DRAIN.
REQ-016 prog_len SHALL be sampled at start; changes during a run SHALL have no effect.

Reset
REQ-017 When rst_n=0 at a clk edge: state=IDLE, pc/batch/total/timer=0, skid empty, Instr_in=0, valid_flag=0, mem_en=0, mem_addr=0, busy=0, done=0.
REQ-018 Reset mid-run SHALL abort immediately, with no done pulse. The first cycle after release SHALL be IDLE.

Structure
REQ-019 The FSM state encoding and default parameter constants SHALL reside in the shared package esm_pkg.
REQ-020 The DRAIN timer SHALL be a sub-module named dispatch_drain_timer (load, enable, expired). All other logic SHALL be flat.

Verification
REQ-021 Bench scenarios:
- prog_len=5, bs=16, DRAIN_CYCLES=16 -> valid_flag high for 5 consecutive cycles starting at N+3, Instr_in = mem[0..4], 16 idle cycles, then done.
- prog_len=40, bs=16 -> batches of 16, 16 and 8, each followed by 16 valid_flag=0 cycles; 40 instructions in order.
- hold high for 3 cycles in the middle of FILL at instruction 7 -> sequence unbroken (7 issued once, after hold drops), with valid_flag=0 during the hold.
- prog_len=0 -> done pulses 2 cycles after start; valid_flag and mem_en never assert.
- rst_n low at instruction 10 of 40 -> all outputs 0 the next cycle; no done; a fresh start then replays from mem[0].
- AW=4, prog_len=16 -> mem_addr 0..15 exactly once each, with no address 0 re-read.
